// File: rtl/retire_tracker.sv
`timescale 1ns/1ps
// retire_tracker: tags every non-bubble write-back retirement with a 64-bit
// order number, buffers the records in a DEPTH-entry FIFO for a valid/ready
// consumer, and checks program-order PC continuity with sticky error flags.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   wb_valid_i                    a non-bubble instruction retires this cycle
//   wb_pc_i, wb_insn_i            retiring PC and instruction word
//   wb_rd_we_i, wb_rd_i           rd write enable and destination register
//   wb_rd_data_i                  write-back data
//   flush_i                       redirect; next retirement's PC is unchecked
//   rt_valid_o / rt_ready_i       head-of-FIFO handshake
//   rt_order_o, rt_pc_o, rt_insn_o, rt_rd_o, rt_rd_we_o, rt_rd_data_o
//                                 head record fields
//   rt_count_o                    FIFO occupancy
//   pc_err_o                      sticky PC-continuity violation
//   ovf_err_o                     sticky dropped-record flag
module retire_tracker #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [31:0] PC_INIT = 32'h200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid_i,
  input  logic [31:0]              wb_pc_i,
  input  logic [31:0]              wb_insn_i,
  input  logic                     wb_rd_we_i,
  input  logic [4:0]               wb_rd_i,
  input  logic [31:0]              wb_rd_data_i,
  input  logic                     flush_i,
  output logic                     rt_valid_o,
  input  logic                     rt_ready_i,
  output logic [63:0]              rt_order_o,
  output logic [31:0]              rt_pc_o,
  output logic [31:0]              rt_insn_o,
  output logic [31:0]              rt_rd_data_o,
  output logic [4:0]               rt_rd_o,
  output logic                     rt_rd_we_o,
  output logic [$clog2(DEPTH):0]   rt_count_o,
  output logic                     pc_err_o,
  output logic                     ovf_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    MODE_SEQ  = 2'd0,
    MODE_JAL  = 2'd1,
    MODE_BR   = 2'd2,
    MODE_NONE = 2'd3
  } mode_e;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
  } rec_t;

  // FIFO storage and bookkeeping
  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_order;
  logic          r_pc_err;
  logic          r_ovf_err;

  // Expected-PC tracker state
  mode_e         r_mode;
  logic [31:0]   r_tgt_a;
  logic [31:0]   r_tgt_b;

  mode_e         w_mode_nxt;
  logic [31:0]   w_tgt_a_nxt;
  logic [31:0]   w_tgt_b_nxt;
  logic          w_pc_bad;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_rd_we;
  rec_t          w_rec;
  logic [31:0]   w_imm_j;
  logic [31:0]   w_imm_b;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && rt_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = wb_valid_i && (!w_full || w_pop);
  assign w_drop = wb_valid_i && !w_push;

  // rd is suppressed for x0 so consumers never see a write to the zero register.
  assign w_rd_we = wb_rd_we_i && (wb_rd_i != 5'd0);

  always_comb begin
    w_rec.order   = r_order;
    w_rec.pc      = wb_pc_i;
    w_rec.insn    = wb_insn_i;
    w_rec.rd      = w_rd_we ? wb_rd_i : 5'd0;
    w_rec.rd_we   = w_rd_we;
    w_rec.rd_data = wb_rd_data_i;
  end

  assign w_imm_j = {{12{wb_insn_i[31]}}, wb_insn_i[19:12], wb_insn_i[20],
                    wb_insn_i[30:21], 1'b0};
  assign w_imm_b = {{20{wb_insn_i[31]}}, wb_insn_i[7], wb_insn_i[30:25],
                    wb_insn_i[11:8], 1'b0};

  // FIFO, order counter and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_order   <= '0;
      r_pc_err  <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_rec;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      // Dropped retirements still consume an order number.
      if (wb_valid_i) begin
        r_order <= r_order + 64'd1;
      end
      if (w_pc_bad) begin
        r_pc_err <= 1'b1;
      end
      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  // Expected-PC state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_SEQ;
      r_tgt_a <= PC_INIT;
      r_tgt_b <= PC_INIT;
    end else begin
      r_mode  <= w_mode_nxt;
      r_tgt_a <= w_tgt_a_nxt;
      r_tgt_b <= w_tgt_b_nxt;
    end
  end

  // Check the retiring PC against the stored mode, then derive the next expectation
  always_comb begin
    w_mode_nxt  = r_mode;
    w_tgt_a_nxt = r_tgt_a;
    w_tgt_b_nxt = r_tgt_b;
    w_pc_bad    = 1'b0;
    if (wb_valid_i) begin
      unique case (r_mode)
        MODE_SEQ, MODE_JAL: w_pc_bad = (wb_pc_i != r_tgt_a);
        MODE_BR:            w_pc_bad = (wb_pc_i != r_tgt_a) && (wb_pc_i != r_tgt_b);
        default:            w_pc_bad = 1'b0;
      endcase
      w_tgt_a_nxt = wb_pc_i + 32'd4;
      w_tgt_b_nxt = wb_pc_i + w_imm_b;
      case (wb_insn_i[6:2])
        5'b11011: begin
          w_mode_nxt  = MODE_JAL;
          w_tgt_a_nxt = wb_pc_i + w_imm_j;
        end
        5'b11000: w_mode_nxt = MODE_BR;
        5'b11001: w_mode_nxt = MODE_NONE;
        default:  w_mode_nxt = MODE_SEQ;
      endcase
    end
    // A flush alongside a retirement affects only the following retirement.
    if (flush_i) begin
      w_mode_nxt = MODE_NONE;
    end
  end

  assign rt_valid_o   = (r_count != '0);
  assign rt_order_o   = r_mem[r_rd_ptr].order;
  assign rt_pc_o      = r_mem[r_rd_ptr].pc;
  assign rt_insn_o    = r_mem[r_rd_ptr].insn;
  assign rt_rd_o      = r_mem[r_rd_ptr].rd;
  assign rt_rd_we_o   = r_mem[r_rd_ptr].rd_we;
  assign rt_rd_data_o = r_mem[r_rd_ptr].rd_data;
  assign rt_count_o   = r_count;
  assign pc_err_o     = r_pc_err;
  assign ovf_err_o    = r_ovf_err;

endmodule

// File: tb/tb_retire_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for retire_tracker: directed scenarios plus randomized
// instruction streams, checked by a queue-based reference model and monitor.
module tb_retire_tracker;

  localparam int unsigned DEPTH   = 8;
  localparam logic [31:0] PC_INIT = 32'h200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic [31:0] wb_insn_i;
  logic        wb_rd_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_rd_data_i;
  logic        flush_i;
  logic        rt_valid_o;
  logic        rt_ready_i;
  logic [63:0] rt_order_o;
  logic [31:0] rt_pc_o;
  logic [31:0] rt_insn_o;
  logic [31:0] rt_rd_data_o;
  logic [4:0]  rt_rd_o;
  logic        rt_rd_we_o;
  logic [$clog2(DEPTH):0] rt_count_o;
  logic        pc_err_o;
  logic        ovf_err_o;

  retire_tracker #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i), .wb_insn_i(wb_insn_i),
    .wb_rd_we_i(wb_rd_we_i), .wb_rd_i(wb_rd_i), .wb_rd_data_i(wb_rd_data_i),
    .flush_i(flush_i),
    .rt_valid_o(rt_valid_o), .rt_ready_i(rt_ready_i),
    .rt_order_o(rt_order_o), .rt_pc_o(rt_pc_o), .rt_insn_o(rt_insn_o),
    .rt_rd_data_o(rt_rd_data_o), .rt_rd_o(rt_rd_o), .rt_rd_we_o(rt_rd_we_o),
    .rt_count_o(rt_count_o), .pc_err_o(pc_err_o), .ovf_err_o(ovf_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] m_allowed[$];
  logic        m_any;
  logic [63:0] m_order;
  logic        m_pc_err;
  logic        m_ovf;
  logic        m_ok;
  rec_t        m_r;
  rec_t        m_h;

  function automatic logic [31:0] j_off(input logic [31:0] i);
    int o;
    o = i[31] ? -(1 << 20) : 0;
    o += int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    return 32'(o);
  endfunction

  function automatic logic [31:0] b_off(input logic [31:0] i);
    int o;
    o = i[31] ? -4096 : 0;
    o += int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    return 32'(o);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_allowed.delete();
      m_allowed.push_back(PC_INIT);
      m_any    = 1'b0;
      m_order  = 64'd0;
      m_pc_err = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (wb_valid_i) begin
        if (!m_any) begin
          m_ok = 1'b0;
          foreach (m_allowed[j]) if (m_allowed[j] == wb_pc_i) m_ok = 1'b1;
          if (!m_ok) m_pc_err = 1'b1;
        end
        // The monitor has already removed an entry leaving at this edge.
        if (exp_q.size() < DEPTH) begin
          m_r.order = m_order;
          m_r.pc    = wb_pc_i;
          m_r.insn  = wb_insn_i;
          m_r.we    = wb_rd_we_i && (wb_rd_i != 5'd0);
          m_r.rd    = m_r.we ? wb_rd_i : 5'd0;
          m_r.data  = wb_rd_data_i;
          exp_q.push_back(m_r);
        end else begin
          m_ovf = 1'b1;
        end
        m_order++;
        m_allowed.delete();
        m_any = 1'b0;
        case (wb_insn_i[6:2])
          5'b11011: m_allowed.push_back(wb_pc_i + j_off(wb_insn_i));
          5'b11000: begin
            m_allowed.push_back(wb_pc_i + 32'd4);
            m_allowed.push_back(wb_pc_i + b_off(wb_insn_i));
          end
          5'b11001: m_any = 1'b1;
          default:  m_allowed.push_back(wb_pc_i + 32'd4);
        endcase
      end
      if (flush_i) m_any = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 64'(rt_count_o), 64'(exp_q.size()));
      chk("valid", 64'(rt_valid_o), 64'(exp_q.size() != 0));
      chk("pc_err", 64'(pc_err_o), 64'(m_pc_err));
      chk("ovf_err", 64'(ovf_err_o), 64'(m_ovf));
      if (exp_q.size() != 0) begin
        m_h = exp_q[0];
        chk("head_order", rt_order_o, m_h.order);
        chk("head_pc", 64'(rt_pc_o), 64'(m_h.pc));
        chk("head_insn", 64'(rt_insn_o), 64'(m_h.insn));
        chk("head_rd", 64'(rt_rd_o), 64'(m_h.rd));
        chk("head_rd_we", 64'(rt_rd_we_o), 64'(m_h.we));
        chk("head_data", 64'(rt_rd_data_o), 64'(m_h.data));
        if (rt_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd);
    return {12'd0, 5'd1, 3'b000, rd, 7'b1100111};
  endfunction

  // Drive one cycle of inputs; returns at posedge+1 with valid/flush cleared.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic we, input logic [4:0] rd, input logic fl);
    wb_valid_i   = v;
    wb_pc_i      = pc;
    wb_insn_i    = insn;
    wb_rd_we_i   = we;
    wb_rd_i      = rd;
    wb_rd_data_i = $urandom;
    flush_i      = fl;
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn);
    step(1'b1, pc, insn, 1'b1, 5'($urandom_range(31)), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    logic [31:0] g_pc, pc, ins, nxt;
    logic [4:0]  rd;
    logic        fl, we;
    int          k, imm;
    g_pc = PC_INIT;
    for (int i = 0; i < n; i++) begin
      rt_ready_i = ($urandom_range(9) < 7);
      if ($urandom_range(3) == 0) begin
        fl = ($urandom_range(15) == 0);
        step(1'b0, $urandom, $urandom, 1'b0, 5'd0, fl);
        if (fl) g_pc = $urandom & ~32'd3;
      end else begin
        pc = ($urandom_range(49) == 0) ? g_pc + 32'd8 : g_pc;
        rd = 5'($urandom_range(31));
        we = 1'($urandom_range(1));
        k  = int'($urandom_range(9));
        if (k < 5) begin
          ins = enc_addi(rd, int'($urandom_range(4095)));
          nxt = pc + 32'd4;
        end else if (k < 7) begin
          imm = (int'($urandom_range(1023)) - 512) * 4;
          ins = enc_jal(rd, imm);
          nxt = pc + 32'(imm);
        end else if (k < 9) begin
          imm = (int'($urandom_range(511)) - 256) * 4;
          ins = enc_beq(imm);
          nxt = ($urandom_range(1) == 1) ? pc + 32'(imm) : pc + 32'd4;
        end else begin
          ins = enc_jalr(rd);
          nxt = $urandom & ~32'd3;
        end
        fl = ($urandom_range(19) == 0);
        if (fl) nxt = $urandom & ~32'd3;
        step(1'b1, pc, ins, we, rd, fl);
        g_pc = nxt;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    wb_valid_i = 1'b0; wb_pc_i = '0; wb_insn_i = '0; wb_rd_we_i = 1'b0;
    wb_rd_i = '0; wb_rd_data_i = '0; flush_i = 1'b0; rt_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rt_valid_o), 64'd0);
    chk("rst_count", 64'(rt_count_o), 64'd0);
    chk("rst_order", rt_order_o, 64'd0);
    chk("rst_pc", 64'(rt_pc_o), 64'd0);
    rst = 1'b0;

    // Sequential addi stream, one-cycle latency
    retire(32'h200, enc_addi(5'd1, 1));
    chk("lat_valid", 64'(rt_valid_o), 64'd1);
    chk("lat_order0", rt_order_o, 64'd0);
    retire(32'h204, enc_addi(5'd2, 2));
    chk("lat_order1", rt_order_o, 64'd1);
    retire(32'h208, enc_addi(5'd3, 3));
    chk("lat_order2", rt_order_o, 64'd2);
    idle(2);
    chk("seq_pc_err", 64'(pc_err_o), 64'd0);

    // JAL correct target, then wrong target
    do_reset();
    retire(32'h200, enc_addi(5'd1, 0));
    retire(32'h204, enc_jal(5'd1, 16));
    retire(32'h214, enc_addi(5'd1, 0));
    chk("jal_ok", 64'(pc_err_o), 64'd0);
    do_reset();
    retire(32'h200, enc_addi(5'd1, 0));
    retire(32'h204, enc_jal(5'd1, 16));
    retire(32'h208, enc_addi(5'd1, 0));
    chk("jal_bad", 64'(pc_err_o), 64'd1);

    // Branch: taken and fall-through pass, other PC fails
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    retire(32'h300, enc_beq(-8));
    step(1'b1, 32'h2F8, enc_addi(5'd4, 0), 1'b1, 5'd4, 1'b1);
    retire(32'h300, enc_beq(-8));
    step(1'b1, 32'h304, enc_addi(5'd4, 0), 1'b1, 5'd4, 1'b1);
    retire(32'h300, enc_beq(-8));
    chk("br_ok", 64'(pc_err_o), 64'd0);
    retire(32'h308, enc_addi(5'd4, 0));
    chk("br_bad", 64'(pc_err_o), 64'd1);

    // Overflow with stalled consumer, then drain and observe order gap
    do_reset();
    rt_ready_i = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) retire(PC_INIT + 32'(4 * i), enc_addi(5'd5, i));
    chk("ovf_count", 64'(rt_count_o), 64'(DEPTH));
    chk("ovf_flag", 64'(ovf_err_o), 64'd1);
    chk("ovf_head", rt_order_o, 64'd0);
    rt_ready_i = 1'b1;
    idle(int'(DEPTH) + 2);
    retire(PC_INIT + 32'(4 * (DEPTH + 1)), enc_addi(5'd5, 0));
    chk("gap_order", rt_order_o, 64'(DEPTH + 1));

    // Flush, JALR, rd=x0 suppression, PC wrap
    do_reset();
    retire(32'h200, enc_addi(5'd1, 0));
    step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    retire(32'h1000, enc_jalr(5'd1));
    retire(32'h5555_0000, enc_addi(5'd1, 0));
    chk("flush_jalr", 64'(pc_err_o), 64'd0);
    idle(2);
    step(1'b1, 32'h5555_0004, enc_addi(5'd0, 7), 1'b1, 5'd0, 1'b1);
    chk("x0_we", 64'(rt_rd_we_o), 64'd0);
    chk("x0_rd", 64'(rt_rd_o), 64'd0);
    retire(32'hFFFF_FFFC, enc_addi(5'd1, 0));
    retire(32'h0000_0000, enc_addi(5'd1, 0));
    idle(1);
    chk("wrap", 64'(pc_err_o), 64'd0);

    // Full FIFO with simultaneous push and pop, then async reset mid-stream
    do_reset();
    rt_ready_i = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) retire(PC_INIT + 32'(4 * i), enc_addi(5'd6, i));
    chk("full_count", 64'(rt_count_o), 64'(DEPTH));
    rt_ready_i = 1'b1;
    retire(PC_INIT + 32'(4 * DEPTH), enc_addi(5'd6, 0));
    chk("pp_count", 64'(rt_count_o), 64'(DEPTH));
    chk("pp_ovf", 64'(ovf_err_o), 64'd0);
    rt_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(rt_valid_o), 64'd0);
    chk("arst_count", 64'(rt_count_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rt_ready_i = 1'b1;
    retire(PC_INIT, enc_addi(5'd7, 0));
    chk("arst_order", rt_order_o, 64'd0);
    idle(2);

    // Randomized streams
    for (int p = 0; p < 4; p++) begin
      do_reset();
      rand_phase(400);
    end
    rt_ready_i = 1'b1;
    idle(int'(DEPTH) + 2);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
